// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  // Default build: 8-bit words, 16 entries.
  localparam int DEF_DWIDTH   = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AE_LEVEL = 2;

  // Pointer width: enough bits to address DEPTH entries, never zero.
  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Occupancy width: must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DWIDTH storage with one write port and one registered read port.
// Array contents are never reset; only the read register is.
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = ptr_w(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  // Write port: store the word at the write address when enabled.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: capture the addressed word on an enabled edge, hold otherwise.
  // A same-edge write to the same address is not forwarded: the old word wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags, read-valid strobe and error pulses.
//
// Handshake: a write is accepted on a rising edge when wr=1 and full=0; a
// read is accepted when rd=1 and empty=0, both judged on the flags as they
// stand before that edge. An accepted read presents its word on dout after
// the edge with dout_valid=1 for exactly that cycle. A write refused because
// the FIFO is full raises overflow for one cycle; a read refused because it
// is empty raises underflow for one cycle. Refused requests change nothing.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr,
  input  logic [DWIDTH-1:0]      din,
  input  logic                   rd,
  output logic [DWIDTH-1:0]      dout,
  output logic                   dout_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  // Reject illegal configurations at elaboration.
  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_sync_param: AF_LEVEL must be within 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_param: AE_LEVEL must be within 0..DEPTH-1");
  end

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dout_valid_q;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;

  // Flags decode straight from the count register, so they are glitch-free.
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign count        = count_q;

  assign wr_acc = wr & ~full;
  assign rd_acc = rd & ~empty;

  // Next-state: pointers advance and wrap naturally; count tracks occupancy.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = wr & full;
    underflow_d = rd & empty;
    if (wr_acc) begin
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (rd_acc) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers: asynchronous clear discards all buffered entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      dout_valid_q <= rd_acc;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

  fifo_mem_2p #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AW     (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (din),
    .re_i    (rd_acc),
    .raddr_i (rptr_q),
    .rdata_o (dout)
  );

endmodule
